// File: rtl/md_scheduler.sv
// HI/LO multiply/divide sequencer: fixed-latency countdown, HI/LO ownership, D-stage stall.
// Optional MD_DIV0_KEEP_EN: divide by zero leaves HI/LO unchanged at completion.
module md_scheduler #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_op,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        D_md_use,
  input  logic        req,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt;
  logic [31:0] p_hi, p_lo;
  logic [31:0] r_hi, r_lo;
  logic [63:0] ext_a, ext_b, prod;
  logic        e_md, is_div, div0, start, done;
`ifdef MD_DIV0_KEEP_EN
  logic        p_keep;
`endif

  assign e_md   = (E_op >= 4'd1) && (E_op <= 4'd4);
  assign is_div = (E_op == 4'd3) || (E_op == 4'd4);
  assign div0   = is_div && (E_rt_val == 32'd0);
  assign start  = e_md && !req && (state_q == IDLE);
  assign done   = (state_q == RUN) && (cnt == 5'd1);
  assign busy   = (state_q == RUN);
  assign stall  = D_md_use && (busy || e_md);

  always_comb begin
    ext_a = {32'd0, E_rs_val};
    ext_b = {32'd0, E_rt_val};
    if (E_op == 4'd1) begin
      ext_a = {{32{E_rs_val[31]}}, E_rs_val};
      ext_b = {{32{E_rt_val[31]}}, E_rt_val};
    end
    prod = ext_a * ext_b;
  end

  always_comb begin
    r_hi = prod[63:32];
    r_lo = prod[31:0];
    if (div0) begin
      r_hi = E_rs_val;
      r_lo = 32'hFFFF_FFFF;
    end else if (E_op == 4'd4) begin
      r_lo = E_rs_val / E_rt_val;
      r_hi = E_rs_val % E_rt_val;
    end else if (E_op == 4'd3) begin
      // INT_MIN / -1 overflows the quotient; pin the architectural result
      if (E_rs_val == 32'h8000_0000 && E_rt_val == 32'hFFFF_FFFF) begin
        r_lo = 32'h8000_0000;
        r_hi = 32'd0;
      end else begin
        r_lo = $signed(E_rs_val) / $signed(E_rt_val);
        r_hi = $signed(E_rs_val) % $signed(E_rt_val);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt     <= 5'd0;
      p_hi    <= 32'd0;
      p_lo    <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
`ifdef MD_DIV0_KEEP_EN
      p_keep  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (start) begin
        p_hi <= r_hi;
        p_lo <= r_lo;
        cnt  <= is_div ? 5'(DIV_CYC) : 5'(MULT_CYC);
`ifdef MD_DIV0_KEEP_EN
        p_keep <= div0;
`endif
      end else if (state_q == RUN) begin
        cnt <= cnt - 5'd1;
      end
`ifdef MD_DIV0_KEEP_EN
      if (done && !p_keep) begin
`else
      if (done) begin
`endif
        hi <= p_hi;
        lo <= p_lo;
      end
      // moves to HI/LO are dropped while an operation owns them
      if (state_q == IDLE && !req) begin
        if (E_op == 4'd5) hi <= E_rs_val;
        if (E_op == 4'd6) lo <= E_rs_val;
      end
    end
  end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler.
// Honours MD_DIV0_KEEP_EN for the divide-by-zero expectation.
module tb_md_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  E_op = 4'd0;
  logic [31:0] E_rs_val = 32'd0;
  logic [31:0] E_rt_val = 32'd0;
  logic        D_md_use = 1'b0;
  logic        req = 1'b0;
  logic        stall, busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int n;

  md_scheduler #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .E_op(E_op),
    .E_rs_val(E_rs_val), .E_rt_val(E_rt_val),
    .D_md_use(D_md_use), .req(req),
    .stall(stall), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      step();
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int c;
    E_op = op; E_rs_val = a; E_rt_val = b;
    step();
    E_op = 4'd0;
    wait_idle(c);
    chk({tag, "_cyc"}, 32'(c), 32'(lat));
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
  endtask

  initial begin
    // reset state; E-stage stall term is live even in reset
    D_md_use = 1'b1; E_op = 4'd1;
    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall), 32'd1);
    D_md_use = 1'b0; E_op = 4'd0;
    #10 reset = 1'b1;
    step();

    // async reset mid-divide discards the operation
    E_op = 4'd5; E_rs_val = 32'h1234;
    step();
    chk("mthi", hi, 32'h1234);
    E_op = 4'd4; E_rs_val = 32'd100; E_rt_val = 32'd7;
    step();
    E_op = 4'd0;
    repeat (6) step();
    chk("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    #2 reset = 1'b1;
    repeat (12) step();
    chk("post_hi", hi, 32'd0);
    chk("post_lo", lo, 32'd0);
    chk("post_busy", 32'(busy), 32'd0);

    run_op("mult", 4'd1, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu", 4'd2, 32'hFFFF_FFFD, 32'd7, 5, 32'd6, 32'hFFFF_FFEB);
    run_op("divu", 4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_neg", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // mflo in D behind a mult in E
    D_md_use = 1'b1; E_op = 4'd1; E_rs_val = 32'd3; E_rt_val = 32'd4;
    #1;
    chk("stall_start", 32'(stall), 32'd1);
    n = 1;
    step();
    E_op = 4'd0;
    while (stall && n < 40) begin
      n++;
      step();
    end
    chk("stall_cyc", 32'(n), 32'd6);
    chk("stall_lo", lo, 32'd12);
    D_md_use = 1'b0;

    // flushed start and flushed mthi
    req = 1'b1; E_op = 4'd1; E_rs_val = 32'd2; E_rt_val = 32'd2;
    D_md_use = 1'b1;
    #1;
    chk("req_stall", 32'(stall), 32'd1);
    step();
    D_md_use = 1'b0;
    chk("req_busy", 32'(busy), 32'd0);
    chk("req_lo", lo, 32'd12);
    E_op = 4'd5; E_rs_val = 32'hABCD;
    step();
    chk("req_mthi", hi, 32'd0);
    req = 1'b0;
    step();
    chk("mthi_ok", hi, 32'hABCD);
    E_op = 4'd6; E_rs_val = 32'h55;
    step();
    chk("mtlo_ok", lo, 32'h55);
    E_op = 4'd0;

`ifdef MD_DIV0_KEEP_EN
    run_op("div0", 4'd3, 32'd5, 32'd0, 10, 32'hABCD, 32'h55);
`else
    run_op("div0", 4'd3, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF);
`endif

    // moves and new starts during RUN are dropped
    E_op = 4'd1; E_rs_val = 32'd2; E_rt_val = 32'd3;
    step();
    E_op = 4'd5; E_rs_val = 32'hDEAD;
    step();
    E_op = 4'd3; E_rs_val = 32'd9; E_rt_val = 32'd3;
    step();
    E_op = 4'd0;
    wait_idle(n);
    chk("run_cyc", 32'(n), 32'd3);
    chk("run_hi", hi, 32'd0);
    chk("run_lo", lo, 32'd6);
    step();
    chk("run_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
